ram_programmer: RTL and testbench

Front-panel programming controller that sits directly upstream of the RAM/MAR stage. It turns the raw address button, write button and DIP switches into clean, single-cycle `addr_load`/`mem_write` strobes with stable address/data, and optionally auto-increments the address after each write. The block is active only in program mode. Its outputs drive the RAM's programming-side address load and write enable in place of hand-timed switch presses.

---
 rtl/ram_programmer.sv | 82 ++++++++
 tb/tb_ram_programmer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_programmer.sv
// ram_programmer: debounced front-panel RAM programmer; buttons/DIP switches in, one-cycle addr_load/mem_write strobes with stable addr_out/data_out and busy out
module ram_programmer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       prog_mode,
  input  logic       auto_inc,
  input  logic       addr_button,
  input  logic       write_button,
  input  logic [3:0] dipswitch_addr,
  input  logic [7:0] dipswitch_data,
  output logic [3:0] addr_out,
  output logic [7:0] data_out,
  output logic       addr_load,
  output logic       mem_write,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, WRITE, INCR} state_t;
  state_t     state_q, state_d;
  logic [1:0] btn, s1_q, s2_q, db_q, dbp_q, ev_q, hit;
  logic [3:0] cur_addr_q, cur_addr_d;
  logic [7:0] data_q, data_d;
  assign btn = {write_button, addr_button};
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [7:0] cnt_q, cnt_d;
    assign cnt_d = (s2_q[i] ^ db_q[i]) ? cnt_q + 8'd1 : 8'd0;
    assign hit[i] = cnt_d == 8'(DEBOUNCE_CYCLES);
    always_ff @(posedge clk or posedge clear)
      if (clear) cnt_q <= 8'd0;
      else cnt_q <= hit[i] ? 8'd0 : cnt_d;
  end
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      s1_q       <= 2'b00;
      s2_q       <= 2'b00;
      db_q       <= 2'b00;
      dbp_q      <= 2'b00;
      ev_q       <= 2'b00;
      state_q    <= IDLE;
      cur_addr_q <= 4'd0;
      data_q     <= 8'd0;
    end else begin
      s1_q       <= btn;
      s2_q       <= s1_q;
      db_q       <= db_q ^ hit;
      dbp_q      <= db_q;
      ev_q       <= db_q & ~dbp_q;
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      data_q     <= data_d;
    end
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    data_d     = data_q;
    if (!prog_mode) state_d = IDLE;
    else
      case (state_q)
        IDLE:
          if (ev_q[0]) begin
            state_d    = LOAD;
            cur_addr_d = dipswitch_addr;
          end else if (ev_q[1]) begin
            state_d = SETUP;
            data_d  = dipswitch_data;
          end
        SETUP:   state_d = WRITE;
        WRITE:   state_d = auto_inc ? INCR : IDLE;
        INCR: begin
          state_d    = IDLE;
          cur_addr_d = cur_addr_q + 4'd1;
        end
        default: state_d = IDLE;
      endcase
  end
  assign addr_out  = cur_addr_q;
  assign data_out  = data_q;
  assign addr_load = state_q == LOAD || state_q == SETUP;
  assign mem_write = state_q == WRITE;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_ram_programmer.sv
// tb_ram_programmer: directed self-checking bench for ram_programmer
module tb_ram_programmer;
  logic       clk = 1'b0, clear = 1'b1, prog_mode = 1'b0, auto_inc = 1'b0;
  logic       addr_button = 1'b0, write_button = 1'b0;
  logic [3:0] dipswitch_addr = 4'd0;
  logic [7:0] dipswitch_data = 8'd0;
  logic [3:0] addr_out;
  logic [7:0] data_out;
  logic       addr_load, mem_write, busy;
  int checks = 0, failures = 0;
  int mw_cnt = 0, al_cnt = 0, overlap = 0, clr_strobe = 0;
  ram_programmer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .clear(clear), .prog_mode(prog_mode), .auto_inc(auto_inc),
    .addr_button(addr_button), .write_button(write_button),
    .dipswitch_addr(dipswitch_addr), .dipswitch_data(dipswitch_data),
    .addr_out(addr_out), .data_out(data_out), .addr_load(addr_load),
    .mem_write(mem_write), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mem_write) mw_cnt++;
    if (addr_load) al_cnt++;
    if (mem_write && addr_load) overlap++;
    if (clear && (mem_write || addr_load)) clr_strobe++;
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    clear = 1'b1;
    tick(3);
    checks++;
    if ({addr_out, data_out, addr_load, mem_write, busy} !== 15'd0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0", {addr_out, data_out, addr_load, mem_write, busy});
    end
    clear = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      checks++;
      if ({addr_out, data_out, addr_load, mem_write, busy} !== 15'd0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d got=%h exp=0", c, {addr_out, data_out, addr_load, mem_write, busy});
      end
    end
  endtask
  task automatic test_addr_set;
    logic [2:0] exp;
    prog_mode = 1'b1;
    dipswitch_addr = 4'hA;
    addr_button = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      exp = {e == 8, 1'b0, e == 8};
      checks++;
      if ({addr_load, mem_write, busy} !== exp) begin
        failures++;
        $display("FAIL addr_set_strobes edge=%0d got=%b exp=%b", e, {addr_load, mem_write, busy}, exp);
      end
      if (e == 8) begin
        checks++;
        if (addr_out !== 4'hA) begin
          failures++;
          $display("FAIL addr_set_addr got=%h exp=a", addr_out);
        end
      end
    end
    addr_button = 1'b0;
    tick(12);
  endtask
  task automatic test_write_autoinc;
    logic [14:0] exp;
    dipswitch_addr = 4'hF;
    addr_button = 1'b1;
    tick(12);
    addr_button = 1'b0;
    tick(12);
    checks++;
    if (addr_out !== 4'hF) begin
      failures++;
      $display("FAIL autoinc_preload got=%h exp=f", addr_out);
    end
    dipswitch_data = 8'h3C;
    auto_inc = 1'b1;
    write_button = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      exp = {e == 8, e == 9, e >= 8 && e <= 10, (e >= 11) ? 4'h0 : 4'hF, (e >= 8) ? 8'h3C : 8'h00};
      checks++;
      if ({addr_load, mem_write, busy, addr_out, data_out} !== exp) begin
        failures++;
        $display("FAIL autoinc_seq edge=%0d got=%h exp=%h", e, {addr_load, mem_write, busy, addr_out, data_out}, exp);
      end
    end
    write_button = 1'b0;
    auto_inc = 1'b0;
    tick(12);
  endtask
  task automatic test_bounce;
    int hs[9] = '{1, 3, 2, 3, 1, 2, 3, 1, 2};
    int ls[9] = '{2, 1, 2, 2, 1, 1, 2, 1, 2};
    int mw0;
    mw0 = mw_cnt;
    dipswitch_data = 8'h5A;
    for (int k = 0; k < 9; k++) begin
      write_button = 1'b1;
      tick(hs[k]);
      write_button = 1'b0;
      tick(ls[k]);
    end
    checks++;
    if (mw_cnt !== mw0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bounce_reject writes=%0d busy=%b exp writes=0 busy=0", mw_cnt - mw0, busy);
    end
    write_button = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      checks++;
      if (mem_write !== (e == 9)) begin
        failures++;
        $display("FAIL bounce_timing edge=%0d got=%b exp=%b", e, mem_write, e == 9);
      end
    end
    tick(20);
    checks++;
    if (mw_cnt - mw0 !== 1 || addr_out !== 4'h0 || data_out !== 8'h5A) begin
      failures++;
      $display("FAIL bounce_total writes=%0d addr=%h data=%h exp writes=1 addr=0 data=5a", mw_cnt - mw0, addr_out, data_out);
    end
    write_button = 1'b0;
    tick(12);
  endtask
  task automatic test_abort;
    int mw0;
    mw0 = mw_cnt;
    dipswitch_data = 8'h77;
    write_button = 1'b1;
    tick(8);
    checks++;
    if ({addr_load, mem_write, busy} !== 3'b101) begin
      failures++;
      $display("FAIL abort_setup got=%b exp=101", {addr_load, mem_write, busy});
    end
    prog_mode = 1'b0;
    tick(1);
    checks++;
    if ({addr_load, mem_write, busy} !== 3'b000) begin
      failures++;
      $display("FAIL abort_idle got=%b exp=000", {addr_load, mem_write, busy});
    end
    tick(3);
    checks++;
    if (mw_cnt !== mw0 || addr_out !== 4'h0 || data_out !== 8'h77) begin
      failures++;
      $display("FAIL abort_state writes=%0d addr=%h data=%h exp writes=0 addr=0 data=77", mw_cnt - mw0, addr_out, data_out);
    end
    write_button = 1'b0;
    tick(12);
    prog_mode = 1'b1;
  endtask
  task automatic test_collision;
    logic [2:0] exp;
    dipswitch_addr = 4'h3;
    dipswitch_data = 8'h99;
    addr_button = 1'b1;
    write_button = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      exp = {e == 8, 1'b0, e == 8};
      checks++;
      if ({addr_load, mem_write, busy} !== exp) begin
        failures++;
        $display("FAIL collision_strobes edge=%0d got=%b exp=%b", e, {addr_load, mem_write, busy}, exp);
      end
    end
    checks++;
    if (addr_out !== 4'h3 || data_out !== 8'h77) begin
      failures++;
      $display("FAIL collision_regs addr=%h data=%h exp addr=3 data=77", addr_out, data_out);
    end
    addr_button = 1'b0;
    write_button = 1'b0;
    tick(12);
  endtask
  task automatic test_midreset;
    auto_inc = 1'b1;
    dipswitch_data = 8'hC5;
    write_button = 1'b1;
    tick(9);
    checks++;
    if ({mem_write, addr_out, data_out} !== {1'b1, 4'h3, 8'hC5}) begin
      failures++;
      $display("FAIL midreset_write got=%h exp=%h", {mem_write, addr_out, data_out}, {1'b1, 4'h3, 8'hC5});
    end
    clear = 1'b1;
    write_button = 1'b0;
    #1;
    checks++;
    if ({addr_out, data_out, addr_load, mem_write, busy} !== 15'd0) begin
      failures++;
      $display("FAIL midreset_async got=%h exp=0", {addr_out, data_out, addr_load, mem_write, busy});
    end
    tick(3);
    clear = 1'b0;
    tick(15);
    checks++;
    if ({addr_out, data_out, addr_load, mem_write, busy} !== 15'd0) begin
      failures++;
      $display("FAIL midreset_after got=%h exp=0", {addr_out, data_out, addr_load, mem_write, busy});
    end
    auto_inc = 1'b0;
  endtask
  task automatic test_invariants;
    checks++;
    if (overlap !== 0 || clr_strobe !== 0) begin
      failures++;
      $display("FAIL invariants overlap=%0d strobe_in_clear=%0d exp 0 0", overlap, clr_strobe);
    end
  endtask
  initial begin
    test_reset();
    test_addr_set();
    test_write_autoinc();
    test_bounce();
    test_abort();
    test_collision();
    test_midreset();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
